qmat_emitter: RTL and testbench

QMAT_EMITTER -- requirements
Module: qmat_emitter

---
 rtl/qmat_pkg.sv | 23 ++
 rtl/qmat_emitter_if.sv | 26 ++
 rtl/qmat_next_sel.sv | 27 ++
 rtl/qmat_emitter.sv | 224 ++++++++++++++++++++++
 tb/tb_qmat_emitter.sv | 213 +++++++++++++++++++++
 5 files changed

// File: rtl/qmat_pkg.sv
// Shared types and constants for the quantisation-matrix emitter.
package qmat_pkg;

    localparam int MAT_DIM    = 8;
    localparam int MAT_ELEMS  = 64;
    localparam int MAT_IDX_W  = 3;   // holds 0..NUM_MAT, so "one past the last" fits
    localparam int BEAT_IDX_W = 6;   // element index 0..63 (or row index 0..7 when packing)

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EMIT = 2'd1,
        DONE = 2'd2
    } state_t;

    // One matrix row, column j in slot j; each element kept in an 8-bit slot.
    typedef logic [MAT_DIM-1:0][7:0] qrow_t;

    // Keep only the low elem_w bits of a raw 32-bit element, zero-extended to a slot.
    function automatic logic [7:0] elem_trim(input logic [31:0] raw, input int elem_w);
        return 8'(raw & ((32'd1 << elem_w) - 32'd1));
    endfunction

endpackage

// File: rtl/qmat_emitter_if.sv
// Beat stream from the emitter to the bit-writer.
interface qmat_emitter_if #(
    parameter int OUT_W = 64
);
    logic             out_ready;
    logic             output_enable;
    logic [OUT_W-1:0] val;
    logic [OUT_W-1:0] size_of_bit;
    logic             flush_bit;

    modport master (
        input  out_ready,
        output output_enable,
        output val,
        output size_of_bit,
        output flush_bit
    );

    modport slave (
        output out_ready,
        input  output_enable,
        input  val,
        input  size_of_bit,
        input  flush_bit
    );
endinterface

// File: rtl/qmat_next_sel.sv
// Finds the lowest enabled matrix index at or above from_idx.
module qmat_next_sel
    import qmat_pkg::*;
#(
    parameter int NUM_MAT = 2
) (
    input  logic [NUM_MAT-1:0]   mask,
    input  logic [MAT_IDX_W-1:0] from_idx,
    output logic [MAT_IDX_W-1:0] next_idx,
    output logic                 none_left
);

    logic hit_s;

    // Scan from the top down so the lowest qualifying index is the last one written.
    always_comb begin
        next_idx  = {MAT_IDX_W{1'b0}};
        none_left = 1'b1;
        hit_s     = 1'b0;
        for (int m = NUM_MAT - 1; m >= 0; m--) begin
            hit_s     = mask[m] && (m >= int'(from_idx));
            next_idx  = hit_s ? MAT_IDX_W'(m) : next_idx;
            none_left = hit_s ? 1'b0 : none_left;
        end
    end

endmodule

// File: rtl/qmat_emitter.sv
// Streams selected 8x8 quantisation matrices to a bit-writer, one element per beat.
// Defining QMAT_PACK8_EN switches to one full row per beat (column 0 most significant).
module qmat_emitter
    import qmat_pkg::*;
#(
    parameter int NUM_MAT = 2,
    parameter int ELEM_W  = 8,
    parameter int OUT_W   = 64
) (
    input  logic                                              clock,
    input  logic                                              reset,
    input  logic                                              start,
    input  logic [NUM_MAT-1:0]                                load_mask,
    input  logic                                              flush_on_done,
    input  logic [NUM_MAT-1:0][MAT_DIM-1:0][MAT_DIM-1:0][31:0] qmat,
    qmat_emitter_if.master                                    beat_if,
    output logic                                              busy,
    output logic                                              done
);

`ifdef QMAT_PACK8_EN
    localparam int BEAT_ELEMS = MAT_DIM;
    localparam logic [BEAT_IDX_W-1:0] LAST_BEAT = 6'd7;
    if (MAT_DIM * ELEM_W > OUT_W) begin : g_pack_width_chk
        $error("qmat_emitter: a packed row of 8*ELEM_W bits does not fit in OUT_W");
    end
`else
    localparam int BEAT_ELEMS = 1;
    localparam logic [BEAT_IDX_W-1:0] LAST_BEAT = 6'd63;
`endif
    localparam logic [OUT_W-1:0] BEAT_BITS = OUT_W'(BEAT_ELEMS * ELEM_W);

    state_t                          state_q, state_d;
    logic [MAT_IDX_W-1:0]            mat_q, mat_d;
    logic [BEAT_IDX_W-1:0]           beat_q, beat_d;
    logic [NUM_MAT-1:0]              mask_q, mask_d;
    logic                            fod_q, fod_d;
    qrow_t [NUM_MAT-1:0][MAT_DIM-1:0] snap_q, snap_d;
    logic                            oe_q, oe_d;
    logic [OUT_W-1:0]                val_q, val_d;
    logic [OUT_W-1:0]                sob_q, sob_d;
    logic                            fb_q, fb_d;
    logic                            busy_q, busy_d;
    logic                            done_q, done_d;

    logic [NUM_MAT-1:0]              sel_mask_s;
    logic [MAT_IDX_W-1:0]            sel_from_s;
    logic [MAT_IDX_W-1:0]            sel_next_s;
    logic                            sel_none_s;
    logic                            load_s;
    logic [2:0]                      ridx_s;
`ifndef QMAT_PACK8_EN
    logic [2:0]                      cidx_s;
`endif
    qrow_t                           row_s;
    logic [OUT_W-1:0]                beat_val_s;

    qmat_next_sel #(.NUM_MAT(NUM_MAT)) u_next_sel (
        .mask      (sel_mask_s),
        .from_idx  (sel_from_s),
        .next_idx  (sel_next_s),
        .none_left (sel_none_s)
    );

    // Next-state, snapshot and next-beat computation; every output is registered.
    always_comb begin
        state_d    = state_q;
        mat_d      = mat_q;
        beat_d     = beat_q;
        mask_d     = mask_q;
        fod_d      = fod_q;
        snap_d     = snap_q;
        oe_d       = oe_q;
        val_d      = val_q;
        sob_d      = sob_q;
        fb_d       = fb_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        sel_mask_s = mask_q;
        sel_from_s = mat_q + 3'd1;
        load_s     = 1'b0;
        row_s      = {($bits(qrow_t)){1'b0}};
        beat_val_s = {OUT_W{1'b0}};
        ridx_s     = 3'd0;
`ifndef QMAT_PACK8_EN
        cidx_s     = 3'd0;
`endif

        case (state_q)
            IDLE: begin
                sel_mask_s = load_mask;
                sel_from_s = 3'd0;
                if (start) begin
                    mask_d = load_mask;
                    fod_d  = flush_on_done;
                    for (int m = 0; m < NUM_MAT; m++) begin
                        for (int i = 0; i < MAT_DIM; i++) begin
                            for (int j = 0; j < MAT_DIM; j++) begin
                                snap_d[m][i][j] = elem_trim(qmat[m][i][j], ELEM_W);
                            end
                        end
                    end
                    if (sel_none_s) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = EMIT;
                        busy_d  = 1'b1;
                        mat_d   = sel_next_s;
                        beat_d  = 6'd0;
                        load_s  = 1'b1;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            EMIT: begin
                if (oe_q && beat_if.out_ready) begin
                    if (beat_q == LAST_BEAT) begin
                        if (sel_none_s) begin
                            state_d = DONE;
                            done_d  = 1'b1;
                            busy_d  = 1'b0;
                            oe_d    = 1'b0;
                            val_d   = {OUT_W{1'b0}};
                            sob_d   = {OUT_W{1'b0}};
                            fb_d    = 1'b0;
                        end else begin
                            mat_d  = sel_next_s;
                            beat_d = 6'd0;
                            load_s = 1'b1;
                        end
                    end else begin
                        beat_d = beat_q + 6'd1;
                        load_s = 1'b1;
                    end
                end else begin
                    state_d = EMIT;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
                oe_d    = 1'b0;
                val_d   = {OUT_W{1'b0}};
                sob_d   = {OUT_W{1'b0}};
                fb_d    = 1'b0;
            end
        endcase

        // The beat being loaded always comes from snap_d, which already holds the
        // freshly captured matrices in the start cycle.
`ifdef QMAT_PACK8_EN
        ridx_s = beat_d[2:0];
`else
        ridx_s = beat_d[5:3];
        cidx_s = beat_d[2:0];
`endif
        for (int m = 0; m < NUM_MAT; m++) begin
            for (int j = 0; j < MAT_DIM; j++) begin
                row_s[j] = (MAT_IDX_W'(m) == mat_d) ? snap_d[m][ridx_s][j] : row_s[j];
            end
        end
`ifdef QMAT_PACK8_EN
        for (int j = 0; j < MAT_DIM; j++) begin
            beat_val_s = (beat_val_s << ELEM_W) | OUT_W'(row_s[j][ELEM_W-1:0]);
        end
`else
        beat_val_s = OUT_W'(row_s[cidx_s]);
`endif

        if (load_s) begin
            oe_d  = 1'b1;
            val_d = beat_val_s;
            sob_d = BEAT_BITS;
            // Only the last beat of the last enabled matrix can reach LAST_BEAT with none left.
            fb_d  = fod_d && (beat_d == LAST_BEAT) && sel_none_s;
        end else begin
            fb_d = fb_d;
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            mat_q   <= 3'd0;
            beat_q  <= 6'd0;
            mask_q  <= {NUM_MAT{1'b0}};
            fod_q   <= 1'b0;
            snap_q  <= {($bits(snap_q)){1'b0}};
            oe_q    <= 1'b0;
            val_q   <= {OUT_W{1'b0}};
            sob_q   <= {OUT_W{1'b0}};
            fb_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            mat_q   <= mat_d;
            beat_q  <= beat_d;
            mask_q  <= mask_d;
            fod_q   <= fod_d;
            snap_q  <= snap_d;
            oe_q    <= oe_d;
            val_q   <= val_d;
            sob_q   <= sob_d;
            fb_q    <= fb_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign beat_if.output_enable = oe_q;
    assign beat_if.val           = val_q;
    assign beat_if.size_of_bit   = sob_q;
    assign beat_if.flush_bit     = fb_q;
    assign busy                  = busy_q;
    assign done                  = done_q;

endmodule

// File: tb/tb_qmat_emitter.sv
// Self-checking bench for qmat_emitter: directed jobs plus randomized jobs,
// compared against a flat list of expected beats built from the matrices at start.
module tb_qmat_emitter;

    localparam int NUM_MAT = 2;
    localparam int ELEM_W  = 8;
    localparam int OUT_W   = 64;
    localparam int MI_W    = $clog2(NUM_MAT);
    localparam int MAX_CYC = 2000;
`ifdef QMAT_PACK8_EN
    localparam int BEAT_ELEMS = 8;
`else
    localparam int BEAT_ELEMS = 1;
`endif
    localparam logic [31:0] ELEM_MASK = 32'((64'd1 << ELEM_W) - 64'd1);

    typedef struct packed {
        logic [OUT_W-1:0] val;
        logic             flush;
    } beat_t;

    logic                                  clock;
    logic                                  reset;
    logic                                  start;
    logic                                  flush_on_done;
    logic [NUM_MAT-1:0]                    load_mask;
    logic [NUM_MAT-1:0][7:0][7:0][31:0]    qmat;
    logic                                  busy;
    logic                                  done;

    beat_t exp_q[$];
    int    n_vec = 0;
    int    n_err = 0;

    qmat_emitter_if #(.OUT_W(OUT_W)) beat_if ();

    qmat_emitter #(
        .NUM_MAT (NUM_MAT),
        .ELEM_W  (ELEM_W),
        .OUT_W   (OUT_W)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .start         (start),
        .load_mask     (load_mask),
        .flush_on_done (flush_on_done),
        .qmat          (qmat),
        .beat_if       (beat_if),
        .busy          (busy),
        .done          (done)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Beat bus must be all zero (outside EMIT / after reset).
    task automatic check_quiet(input string tag);
        check_eq({tag, "_oe"},    64'(beat_if.output_enable), 64'd0);
        check_eq({tag, "_val"},   64'(beat_if.val),           64'd0);
        check_eq({tag, "_sob"},   64'(beat_if.size_of_bit),   64'd0);
        check_eq({tag, "_flush"}, 64'(beat_if.flush_bit),     64'd0);
        check_eq({tag, "_busy"},  64'(busy),                  64'd0);
    endtask

    task automatic fill_qmat(input bit rnd);
        for (int m = 0; m < NUM_MAT; m++)
            for (int i = 0; i < 8; i++)
                for (int j = 0; j < 8; j++)
                    qmat[MI_W'(m)][3'(i)][3'(j)] = rnd ? $urandom : 32'(m * 64 + i * 8 + j);
    endtask

    // Expected beats: enabled matrices ascending, elements in flat raster order.
    task automatic build_model(input logic [NUM_MAT-1:0] mask, input logic fod);
        int total;
        int k;
        beat_t b;
        logic [OUT_W-1:0] v;
        exp_q.delete();
        total = 0;
        for (int m = 0; m < NUM_MAT; m++)
            if (mask[MI_W'(m)]) total += 64 / BEAT_ELEMS;
        k = 0;
        for (int m = 0; m < NUM_MAT; m++) begin
            if (mask[MI_W'(m)]) begin
                for (int e = 0; e < 64; e += BEAT_ELEMS) begin
                    v = '0;
                    for (int x = 0; x < BEAT_ELEMS; x++)
                        v = (v << ELEM_W) |
                            OUT_W'(qmat[MI_W'(m)][3'((e + x) / 8)][3'((e + x) % 8)] & ELEM_MASK);
                    k++;
                    b.val   = v;
                    b.flush = fod && (k == total);
                    exp_q.push_back(b);
                end
            end
        end
    endtask

    // rmode: 0 ready always, 1 ready pattern 1,0,0,1, 2 random. abort_at>=0 resets at that beat.
    task automatic run_job(input logic [NUM_MAT-1:0] mask, input logic fod, input int rmode,
                           input bit rnd, input int abort_at);
        int    cyc;
        int    popped;
        int    nb;
        bit    fin;
        logic  rdy;
        beat_t b;
        @(negedge clock);
        check_quiet("pre_start");
        fill_qmat(rnd);
        load_mask         = mask;
        flush_on_done     = fod;
        start             = 1'b1;
        beat_if.out_ready = 1'b1;
        build_model(mask, fod);
        nb     = exp_q.size();
        cyc    = 0;
        popped = 0;
        fin    = 1'b0;
        while (!fin) begin
            @(negedge clock);
            cyc++;
            start = ($urandom_range(0, 15) == 0);
            qmat[MI_W'($urandom_range(0, NUM_MAT - 1))][3'($urandom_range(0, 7))]
                [3'($urandom_range(0, 7))] = $urandom;
            if (exp_q.size() == 0) begin
                check_eq("done_pulse", 64'(done), 64'd1);
                check_quiet("done_cyc");
                if (rmode == 0) check_eq("done_time", 64'(cyc), 64'(nb + 1));
                start = 1'b1;
                @(negedge clock);
                start = 1'b0;
                check_eq("done_once", 64'(done), 64'd0);
                check_quiet("after_done");
                fin = 1'b1;
            end else if (cyc > MAX_CYC) begin
                check_eq("timeout", 64'(cyc), 64'd0);
                exp_q.delete();
                reset = 1'b1;
                @(negedge clock);
                reset = 1'b0;
                fin   = 1'b1;
            end else begin
                b = exp_q[0];
                check_eq("beat_oe",    64'(beat_if.output_enable), 64'd1);
                check_eq("beat_val",   64'(beat_if.val),           64'(b.val));
                check_eq("beat_sob",   64'(beat_if.size_of_bit),   64'(ELEM_W * BEAT_ELEMS));
                check_eq("beat_flush", 64'(beat_if.flush_bit),     64'(b.flush));
                check_eq("beat_busy",  64'(busy),                  64'd1);
                check_eq("beat_done",  64'(done),                  64'd0);
                if (abort_at >= 0 && popped == abort_at) begin
                    reset             = 1'b1;
                    start             = 1'b1;
                    beat_if.out_ready = 1'b1;
                    @(negedge clock);
                    reset = 1'b0;
                    start = 1'b0;
                    check_quiet("rst_mid");
                    check_eq("rst_mid_done", 64'(done), 64'd0);
                    exp_q.delete();
                    fin = 1'b1;
                end else begin
                    case (rmode)
                        0:       rdy = 1'b1;
                        1:       rdy = (((cyc - 1) % 4) == 0) || (((cyc - 1) % 4) == 3);
                        default: rdy = 1'($urandom_range(0, 1));
                    endcase
                    beat_if.out_ready = rdy;
                    if (rdy) begin
                        void'(exp_q.pop_front());
                        popped++;
                    end
                end
            end
        end
        start = 1'b0;
    endtask

    initial begin
        reset             = 1'b1;
        start             = 1'b0;
        load_mask         = '0;
        flush_on_done     = 1'b0;
        beat_if.out_ready = 1'b0;
        fill_qmat(1'b0);
        repeat (3) @(negedge clock);
        check_quiet("reset");
        check_eq("reset_done", 64'(done), 64'd0);
        reset = 1'b0;

        run_job(2'b11, 1'b0, 0, 1'b0, -1);   // full stream 0..127, done at start+129
        run_job(2'b10, 1'b0, 0, 1'b0, -1);   // chroma only, 64..127
        run_job(2'b11, 1'b0, 1, 1'b0, -1);   // stalls 1,0,0,1
        run_job(2'b11, 1'b1, 0, 1'b0, -1);   // flush on final beat
        run_job(2'b00, 1'b1, 0, 1'b0, -1);   // empty mask
        run_job(2'b11, 1'b0, 0, 1'b0, 30);   // reset mid-stream (with start)
        run_job(2'b11, 1'b0, 0, 1'b0, -1);   // restarts at val 0
        for (int t = 0; t < 6; t++)
            run_job(NUM_MAT'($urandom), 1'($urandom), 2, 1'b1, -1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
